spram_x32: RTL and testbench
============================

Name: spram_x32

Overview:
- Single-port 32-bit-wide synchronous RAM with a Wishbone B4 pipelined slave port.
- Used as combined instruction/data memory behind the shared-bus interconnect in the ibex_wb system (base 0x0000_0000, 64 KiB).
- Contents are preloaded by simulation through the hierarchical array `mem` via $readmemh. Reset does not initialise the array.

Parameters:
- size, 'h10000, memory size in bytes. Must be a power of two and ≥ 8. First positional parameter.
- addr_width, 32, Wishbone address width in bits.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- cyc  input  1  Wishbone bus-cycle valid.
- stb  input  1  Wishbone strobe (request valid).
- we  input  1  1 = write, 0 = read.
- adr  input  addr_width  byte address.
- dat_i  input  32  write data (master to slave).
- sel  input  4  byte enables; sel[n] covers bits 8n+7:8n.
- ack  output  1  transfer acknowledge.
- stall  output  1  pipeline stall.
- err  output  1  error response.
- dat_o  output  32  read data (slave to master).

Behaviour:
- Storage: array `mem` of size/4 words of 32 bits, indexed [0:size/4-1]. The name and orientation are fixed so $readmemh with word-per-line vmem loads word 0 at index 0.
- Word index = adr[log2(size)-1:2]. adr[1:0] and bits above log2(size) are ignored; base decode is done by the interconnect.
- Request accepted in any cycle where cyc & stb & !stall.
- stall is constant 0, so back-to-back requests are accepted every cycle.
- Write (we=1): on the accepting edge, each byte lane with sel[n]=1 is updated from dat_i. Lanes with sel[n]=0 are unchanged. sel=0 is a legal no-op write that is still acked.
- Read (we=0): dat_o is registered and loaded on the accepting edge with mem[index], i.e. old data. It is valid in the ack cycle. sel is ignored for reads; the full word is returned.
- Read-after-write to the same word in consecutive cycles returns the newly written data; writes complete at the edge before the next read samples.
- Latency: ack is asserted exactly one cycle after acceptance, one ack per accepted request, in order.
- ack = ack_q & cyc. If the master drops cyc in the ack cycle, the ack is suppressed; the write has already taken effect.
- dat_o holds its last value when not acking and is not cleared on writes.
- err is constant 0.
- Reset (synchronous):
  - ack_q ← 0; a pending ack is cancelled even if issued the cycle before.
  - dat_o ← 0.
  - mem is not modified.
  - Requests presented while rst=1 are not accepted: no write occurs and no ack follows.
- Wrap-around: addresses at or beyond size alias modulo size.

Decomposition:
- Package wb_pkg, shared with ibex_wb, the interconnect and wb_checker: data width 32, sel width 4, addr_width default.
- No sub-module. Byte-lane write is a generate loop over 4 lanes.
- Top-level wrapper binds to the codebase wb_if slave modport (wb.cyc, wb.stb, …; clock and reset taken from the interface's clk/rst).

Test Plan:
- Preload: $readmemh with word 0 = 32'h0000_0093 and word 1 = 32'h00100113. Read adr 0 then adr 4 back-to-back. Expected: ack on cycles 1 and 2, dat_o = 0000_0093 then 0010_0113, stall=0 throughout.
- Byte write: write 32'hAABBCCDD to adr 8 with sel=4'b1111. Then write 32'h1122_3344 to adr 8 with sel=4'b0101. Read adr 8. Expected: dat_o = AA22CC44.
- Pipelined RAW: write 32'hDEADBEEF to adr 'h100, then read 'h100 in the next cycle. Expected: read ack returns DEADBEEF. Each request is acked exactly one cycle after issue.
- Aliasing: write 32'h12345678 to adr 'h1_0000 (size='h10000). Read adr 0. Expected: 12345678. Also check adr 'h0003 reads the same word as adr 0.
- Reset mid-operation: issue a read, assert rst on the next edge. Expected: no ack, dat_o=0, mem contents preserved, and a later read returns the pre-reset data.
- Cyc abort / no-op: drop cyc in the ack cycle, expected ack=0. A write with sel=0 is acked with memory unchanged. err stays 0 throughout, checked by wb_checker.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions used by the memory, interconnect and bus checker.
package wb_pkg;

    localparam int unsigned data_width = 32;
    localparam int unsigned sel_width  = data_width / 8;
    localparam int unsigned addr_width = 32;

    typedef logic [data_width-1:0] wb_data_t;
    typedef logic [sel_width-1:0]  wb_sel_t;

    // Width of the word index for a memory of mem_bytes bytes.
    function automatic int unsigned word_index_bits(input int unsigned mem_bytes);
        return $clog2(mem_bytes) - 2;
    endfunction

endpackage

// File: rtl/spram_x32.sv
// Single-port 32-bit synchronous RAM with a Wishbone B4 pipelined slave port.
// The array `mem` is left unreset so simulation can preload it hierarchically.
module spram_x32
    import wb_pkg::*;
#(
    parameter int unsigned size       = 'h10000,
    parameter int unsigned addr_width = wb_pkg::addr_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc,
    input  logic                  stb,
    input  logic                  we,
    input  logic [addr_width-1:0] adr,
    input  wb_data_t              dat_i,
    input  wb_sel_t               sel,
    output logic                  ack,
    output logic                  stall,
    output logic                  err,
    output wb_data_t              dat_o
);

    localparam int unsigned byte_bits  = $clog2(size);
    localparam int unsigned idx_width  = word_index_bits(size);
    localparam int unsigned num_words  = size / 4;

    // Word-per-line orientation so a word-per-line image puts word 0 at index 0.
    wb_data_t mem [0:num_words-1];

    logic                 accept;
    logic                 wr_en;
    logic                 rd_en;
    logic [idx_width-1:0] idx;
    logic [sel_width-1:0] lane_we;
    logic                 ack_q;
    wb_data_t             dat_q;

    // Address bits outside the word index are decoded by the interconnect.
    logic unused_adr;
    assign unused_adr = ^{adr[1:0], adr[addr_width-1:byte_bits]};

    // Requests seen while in reset are dropped: no write and no ack.
    always_comb begin
        accept = cyc & stb & ~stall & ~rst;
        wr_en  = accept & we;
        rd_en  = accept & ~we;
        idx    = adr[byte_bits-1:2];
    end

    // Per-lane write enables.
    for (genvar g = 0; g < int'(sel_width); g++) begin : g_lane
        assign lane_we[g] = wr_en & sel[g];
    end

    // Byte-lane writes into the array; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        for (int n = 0; n < int'(sel_width); n++) begin
            if (lane_we[n]) begin
                mem[idx][8*n +: 8] <= dat_i[8*n +: 8];
            end
        end
    end

    // Acknowledge one cycle after acceptance; reads return the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept;
            if (rd_en) begin
                dat_q <= mem[idx];
            end
        end
    end

    assign ack   = ack_q & cyc;
    assign dat_o = dat_q;
    assign stall = 1'b0;
    assign err   = 1'b0;

endmodule

// File: tb/tb_spram_x32.sv
// Directed self-checking bench for spram_x32.
module tb_spram_x32;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        ack;
    logic        stall;
    logic        err;
    logic [31:0] dat_o;

    int n_checks = 0;
    int n_errors = 0;

    spram_x32 #(
        .size       ('h10000),
        .addr_width (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cyc   (cyc),
        .stb   (stb),
        .we    (we),
        .adr   (adr),
        .dat_i (dat_i),
        .sel   (sel),
        .ack   (ack),
        .stall (stall),
        .err   (err),
        .dat_o (dat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] se);
        cyc   = c;
        stb   = s;
        we    = w;
        adr   = a;
        dat_i = d;
        sel   = se;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_ok(input string tag);
        check({tag, "_stall"}, {31'b0, stall}, 32'h0);
        check({tag, "_err"},   {31'b0, err},   32'h0);
    endtask

    initial begin
        dut.mem[0] = 32'h0000_0093;
        dut.mem[1] = 32'h0010_0113;
        dut.mem[8] = 32'hCAFE_0008;
        rst = 1'b1;
        idle();
        tick();
        tick();
        check("rst_ack",   {31'b0, ack}, 32'h0);
        check("rst_dat_o", dat_o, 32'h0);
        bus_ok("rst");
        rst = 1'b0;

        // Back-to-back reads of preloaded words.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("rd0_ack", {31'b0, ack}, 32'h1);
        check("rd0_dat", dat_o, 32'h0000_0093);
        bus_ok("rd0");
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        tick();
        check("rd1_ack", {31'b0, ack}, 32'h1);
        check("rd1_dat", dat_o, 32'h0010_0113);
        bus_ok("rd1");
        idle();
        tick();
        check("idle_ack", {31'b0, ack}, 32'h0);
        check("idle_hold", dat_o, 32'h0010_0113);

        // Byte-lane writes.
        drive(1'b1, 1'b1, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b1111);
        tick();
        check("bw0_ack", {31'b0, ack}, 32'h1);
        check("bw0_dat_keep", dat_o, 32'h0010_0113);
        drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h1122_3344, 4'b0101);
        tick();
        check("bw1_ack", {31'b0, ack}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        tick();
        check("bw_rd_ack", {31'b0, ack}, 32'h1);
        check("bw_rd_dat", dat_o, 32'hAA22_CC44);

        // Read immediately after write to the same word.
        drive(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111);
        tick();
        check("raw_w_ack", {31'b0, ack}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        tick();
        check("raw_r_ack", {31'b0, ack}, 32'h1);
        check("raw_r_dat", dat_o, 32'hDEAD_BEEF);
        idle();
        tick();
        check("raw_no_extra_ack", {31'b0, ack}, 32'h0);

        // Address aliasing above size and low byte bits ignored.
        drive(1'b1, 1'b1, 1'b1, 32'h1_0000, 32'h1234_5678, 4'b1111);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("alias0_dat", dat_o, 32'h1234_5678);
        drive(1'b1, 1'b1, 1'b0, 32'h3, 32'h0, 4'h0);
        tick();
        check("alias3_ack", {31'b0, ack}, 32'h1);
        check("alias3_dat", dat_o, 32'h1234_5678);

        // Reset cancels a pending ack and clears dat_o, memory survives.
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        tick();
        check("prerst_ack", {31'b0, ack}, 32'h1);
        rst = 1'b1;
        // Write presented under reset must be ignored.
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h5555_5555, 4'b1111);
        tick();
        check("inrst_ack", {31'b0, ack}, 32'h0);
        check("inrst_dat", dat_o, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("rst_req_no_ack", {31'b0, ack}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        tick();
        check("postrst_ack", {31'b0, ack}, 32'h1);
        check("postrst_dat", dat_o, 32'hAA22_CC44);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        check("rstwr_ignored", dat_o, 32'hCAFE_0008);

        // Master drops cyc in the ack cycle.
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        tick();
        idle();
        #1;
        check("abort_ack", {31'b0, ack}, 32'h0);
        tick();

        // sel=0 write is acked and changes nothing, dat_o held.
        drive(1'b1, 1'b1, 1'b1, 32'h100, 32'h0000_0000, 4'b0000);
        tick();
        check("sel0_ack", {31'b0, ack}, 32'h1);
        check("sel0_dat_hold", dat_o, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        tick();
        check("sel0_rd_dat", dat_o, 32'hDEAD_BEEF);
        bus_ok("end");
        idle();
        tick();
        check("end_ack", {31'b0, ack}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
